// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared core constants (datapath width, reset PC, fetch states)
// Revision  : 1.0
// ============================================================================
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // Fetch sequencer state encodings
  localparam logic [1:0] C_ST_FETCH = 2'd0;
  localparam logic [1:0] C_ST_WAIT  = 2'd1;
  localparam logic [1:0] C_ST_KILL  = 2'd2;
  localparam logic [1:0] C_ST_HOLD  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/PC_Adder.sv
`default_nettype none
// ============================================================================
// PC_Adder : sequential-PC incrementer, wraps modulo 2^XLEN
// Revision : 1.0
// ============================================================================
module PC_Adder
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  assign o_pc_plus4 = i_pc + XLEN'(PC_INCR);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : PC owner and single-outstanding instruction fetch sequencer
// Revision      : 1.0
// ============================================================================
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            redirect_misaligned,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [31:0]     if_instr
);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pc_plus4;
  logic [31:0]     r_if_instr;
  logic            r_misaligned;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_req_pc_plus4;
  logic [XLEN-1:0] w_redirect_target;

  assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  PC_Adder #(.XLEN(XLEN)) u_pc_adder (
    .i_pc       (r_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  PC_Adder #(.XLEN(XLEN)) u_req_pc_adder (
    .i_pc       (r_req_pc),
    .o_pc_plus4 (w_req_pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= C_ST_FETCH;
      r_pc          <= {RESET_PC[XLEN-1:2], 2'b00};
      r_req_pc      <= '0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_instr    <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      r_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);

      // A redirect always retargets the PC, whatever the sequencer is doing
      if (redirect_valid) begin
        r_pc <= w_redirect_target;
      end

      case (r_state)
        C_ST_FETCH: begin
          if (!redirect_valid && imem_req_ready) begin
            r_req_pc <= r_pc;
            r_pc     <= w_pc_plus4;
            r_state  <= C_ST_WAIT;
          end
        end
        C_ST_WAIT: begin
          if (redirect_valid) begin
            // Outstanding read is now stale; KILL swallows its late response
            r_state <= imem_resp_valid ? C_ST_FETCH : C_ST_KILL;
          end else if (imem_resp_valid) begin
            r_if_instr    <= imem_resp_data;
            r_if_pc       <= r_req_pc;
            r_if_pc_plus4 <= w_req_pc_plus4;
            r_if_valid    <= 1'b1;
            r_state       <= C_ST_HOLD;
          end
        end
        C_ST_KILL: begin
          if (imem_resp_valid) begin
            r_state <= C_ST_FETCH;
          end
        end
        C_ST_HOLD: begin
          if (redirect_valid || if_ready) begin
            r_if_valid <= 1'b0;
            r_state    <= C_ST_FETCH;
          end
        end
        default: begin
          r_state <= C_ST_FETCH;
        end
      endcase
    end
  end

  assign imem_req_valid      = (r_state == C_ST_FETCH) && !redirect_valid && !rst;
  assign imem_req_addr       = r_pc;
  assign if_valid            = r_if_valid && !rst;
  assign if_pc               = r_if_pc;
  assign if_pc_plus4         = r_if_pc_plus4;
  assign if_instr            = r_if_instr;
  assign redirect_misaligned = r_misaligned && !rst;

  // Memory may only answer while a request is outstanding
  a_resp_in_window: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (r_state == C_ST_WAIT || r_state == C_ST_KILL));

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_unit : directed vectors plus randomized run against a fetch model
// Revision         : 1.0
// ============================================================================
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_misaligned;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  // Second instance exercising the wrapping reset PC
  logic        b_redirect_valid;
  logic [31:0] b_redirect_pc;
  logic        b_redirect_misaligned;
  logic        b_req_valid;
  logic        b_req_ready;
  logic [31:0] b_req_addr;
  logic        b_resp_valid;
  logic [31:0] b_resp_data;
  logic        b_if_valid;
  logic        b_if_ready;
  logic [31:0] b_if_pc;
  logic [31:0] b_if_pc_plus4;
  logic [31:0] b_if_instr;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .redirect_misaligned (redirect_misaligned),
    .imem_req_valid      (imem_req_valid),
    .imem_req_ready      (imem_req_ready),
    .imem_req_addr       (imem_req_addr),
    .imem_resp_valid     (imem_resp_valid),
    .imem_resp_data      (imem_resp_data),
    .if_valid            (if_valid),
    .if_ready            (if_ready),
    .if_pc               (if_pc),
    .if_pc_plus4         (if_pc_plus4),
    .if_instr            (if_instr)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk                 (clk),
    .rst                 (rst),
    .redirect_valid      (b_redirect_valid),
    .redirect_pc         (b_redirect_pc),
    .redirect_misaligned (b_redirect_misaligned),
    .imem_req_valid      (b_req_valid),
    .imem_req_ready      (b_req_ready),
    .imem_req_addr       (b_req_addr),
    .imem_resp_valid     (b_resp_valid),
    .imem_resp_data      (b_resp_data),
    .if_valid            (b_if_valid),
    .if_ready            (b_if_ready),
    .if_pc               (b_if_pc),
    .if_pc_plus4         (b_if_pc_plus4),
    .if_instr            (b_if_instr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    logic        ifr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic resp, input logic [31:0] rdata, input logic ifr,
                              input logic e_req, input logic [31:0] e_addr, input logic e_ifv,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_mis);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.resp = resp; v.rdata = rdata; v.ifr = ifr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc;
    v.e_instr = e_instr; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    imem_req_ready   = 1'b0;
    imem_resp_valid  = 1'b0;
    imem_resp_data   = '0;
    if_ready         = 1'b0;
    b_redirect_valid = 1'b0;
    b_redirect_pc    = '0;
    b_req_ready      = 1'b0;
    b_resp_valid     = 1'b0;
    b_resp_data      = '0;
    b_if_ready       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    #1;
    chk("reset.req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset.if_valid", 32'(if_valid), 32'd0);
    chk("reset.if_pc", if_pc, 32'd0);
    chk("reset.if_instr", if_instr, 32'd0);
    chk("reset.misaligned", 32'(redirect_misaligned), 32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    rst             = 1'b0;
    redirect_valid  = v.rv;
    redirect_pc     = v.rpc;
    imem_req_ready  = v.rdy;
    imem_resp_valid = v.resp;
    imem_resp_data  = v.rdata;
    if_ready        = v.ifr;
    #1;
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(v.e_req));
    if (v.e_req) chk({tag, ".req_addr"}, imem_req_addr, v.e_addr);
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(v.e_ifv));
    if (v.e_ifv) begin
      chk({tag, ".if_pc"}, if_pc, v.e_pc);
      chk({tag, ".if_pc_plus4"}, if_pc_plus4, v.e_pc + 32'd4);
      chk({tag, ".if_instr"}, if_instr, v.e_instr);
    end
    chk({tag, ".misaligned"}, 32'(redirect_misaligned), 32'(v.e_mis));
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Transaction-level reference: next fetch PC, one in-flight read, one decode entry
  logic [31:0] m_pc, m_opc, m_ent_pc, m_ent_instr;
  logic        m_out, m_kill, m_ent, m_mis;

  localparam logic [31:0] I0 = 32'h0050_0093;
  localparam logic [31:0] D1 = 32'h0040_0113;
  localparam logic [31:0] D2 = 32'h0080_0193;
  localparam logic [31:0] D3 = 32'h00C0_0213;
  localparam logic [31:0] D4 = 32'h1000_0297;

  initial begin
    rst = 1'b1;
    drive_idle();

    // Sequential fetch with a long HOLD, a misaligned FETCH redirect, a WAIT redirect
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, I0, 0, 0, 0,       0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0, I0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0,       1, 32'h0, I0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'h4,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, D1, 0, 0, 0,       0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0,       1, 32'h4, D1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'h8,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, D2, 0, 0, 0,       0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0,       1, 32'h8, D2, 0));
    vecs.push_back(mk(1, 32'h202, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'h200, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, D3, 0, 0, 0,       0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0,       1, 32'h200, D3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'h204, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0,       0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 1, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, D4, 0, 0, 0,       0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0,       1, 32'h100, D4, 0));

    do_reset();
    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a read is outstanding at 0x40
    apply_vec(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rstwait.redir");
    apply_vec(mk(0, 0, 1, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0), "rstwait.req");
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    imem_req_ready = 1'b1;
    #1;
    chk("rstwait.req_valid", 32'(imem_req_valid), 32'd0);
    chk("rstwait.if_valid", 32'(if_valid), 32'd0);
    apply_vec(mk(0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0), "rstwait.after");

    // Wrap of pc+4 on the instance reset to the top word
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    b_req_ready = 1'b1;
    b_if_ready  = 1'b1;
    #1;
    chk("wrap.req_addr0", b_req_addr, 32'hFFFF_FFFC);
    chk("wrap.req_valid0", 32'(b_req_valid), 32'd1);
    @(negedge clk);
    b_req_ready  = 1'b0;
    b_resp_valid = 1'b1;
    b_resp_data  = D1;
    @(negedge clk);
    b_resp_valid = 1'b0;
    #1;
    chk("wrap.if_valid", 32'(b_if_valid), 32'd1);
    chk("wrap.if_pc", b_if_pc, 32'hFFFF_FFFC);
    chk("wrap.if_pc_plus4", b_if_pc_plus4, 32'h0);
    @(negedge clk);
    b_req_ready = 1'b1;
    #1;
    chk("wrap.req_addr1", b_req_addr, 32'h0);
    @(negedge clk);
    b_req_ready = 1'b0;

    // Randomized run against the reference model
    do_reset();
    m_pc = 32'h0; m_opc = '0; m_ent_pc = '0; m_ent_instr = '0;
    m_out = 1'b0; m_kill = 1'b0; m_ent = 1'b0; m_mis = 1'b0;
    begin
      int          mem_cnt;
      logic [31:0] mem_data;
      logic        acc, idle, ent_old;
      logic [31:0] acc_addr;
      mem_cnt  = 0;
      mem_data = '0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        rst             = 1'b0;
        redirect_valid  = ($urandom_range(0, 9) == 0);
        redirect_pc     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                      : $urandom;
        imem_req_ready  = ($urandom_range(0, 2) != 0);
        imem_resp_valid = (mem_cnt == 1);
        imem_resp_data  = mem_data;
        if_ready        = $urandom_range(0, 1) == 1;
        #1;
        idle = !m_out && !m_ent;
        chk("rand.req_valid", 32'(imem_req_valid), 32'(idle && !redirect_valid));
        if (idle && !redirect_valid) chk("rand.req_addr", imem_req_addr, m_pc);
        chk("rand.if_valid", 32'(if_valid), 32'(m_ent));
        if (m_ent) begin
          chk("rand.if_pc", if_pc, m_ent_pc);
          chk("rand.if_pc_plus4", if_pc_plus4, m_ent_pc + 32'd4);
          chk("rand.if_instr", if_instr, m_ent_instr);
        end
        chk("rand.misaligned", 32'(redirect_misaligned), 32'(m_mis));
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        @(posedge clk);
        ent_old = m_ent;
        m_mis   = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (m_out && imem_resp_valid) begin
          if (!m_kill && !redirect_valid) begin
            m_ent       = 1'b1;
            m_ent_pc    = m_opc;
            m_ent_instr = imem_resp_data;
          end
          m_out  = 1'b0;
          m_kill = 1'b0;
        end else if (m_out && redirect_valid) begin
          m_kill = 1'b1;
        end
        if (redirect_valid) begin
          m_pc  = redirect_pc & 32'hFFFF_FFFC;
          m_ent = 1'b0;
        end else if (idle && imem_req_ready) begin
          m_out = 1'b1;
          m_opc = m_pc;
          m_pc  = m_pc + 32'd4;
        end else if (ent_old && if_ready) begin
          m_ent = 1'b0;
        end
        if (mem_cnt > 0) mem_cnt--;
        if (acc) begin
          mem_cnt  = $urandom_range(1, 3);
          mem_data = mem_word(acc_addr);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
